// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, opcodes,
// instruction field positions and small decode helpers.
package core_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int OPC_WIDTH  = 4;
  localparam int IMM_WIDTH  = 6;

  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 4'h0;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 4'h8;
  localparam logic [OPC_WIDTH-1:0] LOAD_OPC = 4'hA;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  // Opcodes 0-7 read two registers; 8-15 read rs1 plus an immediate.
  function automatic logic is_rtype(input logic [OPC_WIDTH-1:0] opc);
    return ~opc[OPC_WIDTH-1];
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: newest producer wins (EX, then WB, then the
// register file read port).
module fwd_mux
  import core_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  ex_valid,
  input  logic                  ex_wr,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  wb_wr,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    // A load in EX has no data yet; the load-use stall covers that case.
    if (ex_valid && ex_wr && !ex_is_load && (ex_waddr == rs)) begin
      fwd_data = ex_wdata;
    end else if (wb_wr && (wb_waddr == rs)) begin
      fwd_data = wb_wdata;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/operand-fetch stage: decode, register read with bypass, load-use stall,
// ID/EX register. Optional stall counter enabled by OPFETCH_STALL_CNT_EN.
module operand_fetch_stage
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] rf_addr1,
  output logic [ADDR_WIDTH-1:0] rf_addr2,
  input  logic [DATA_WIDTH-1:0] rf_data1,
  input  logic [DATA_WIDTH-1:0] rf_data2,
  input  logic                  ex_valid,
  input  logic                  ex_wr,
  input  logic [ADDR_WIDTH-1:0] ex_waddr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic                  ex_is_load,
  input  logic                  wb_wr,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  id_valid,
  output logic [OPC_WIDTH-1:0]  id_opc,
  output logic [ADDR_WIDTH-1:0] id_rd,
  output logic [DATA_WIDTH-1:0] id_opa,
  output logic [DATA_WIDTH-1:0] id_opb,
  output logic [DATA_WIDTH-1:0] id_pc
`ifdef OPFETCH_STALL_CNT_EN
  ,output logic [15:0]          stall_cnt
`endif
);

  logic [OPC_WIDTH-1:0]  opc;
  logic [ADDR_WIDTH-1:0] rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [IMM_WIDTH-1:0]  imm6;
  logic                  rtype;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] fwd1;
  logic [DATA_WIDTH-1:0] fwd2;
  logic [DATA_WIDTH-1:0] opb_sel;

  assign opc   = if_instr[OPC_MSB:OPC_LSB];
  assign rd    = if_instr[RD_MSB:RD_LSB];
  assign rs1   = if_instr[RS1_MSB:RS1_LSB];
  assign rs2   = if_instr[RS2_MSB:RS2_LSB];
  assign imm6  = if_instr[IMM_MSB:IMM_LSB];
  assign rtype = is_rtype(opc);

  assign rf_addr1 = rs1;
  assign rf_addr2 = rs2;

  // I-type instructions reuse the rs2 bits as immediate, so they never hazard on them.
  assign hazard = if_valid && ex_valid && ex_is_load && ex_wr &&
                  ((ex_waddr == rs1) || (rtype && (ex_waddr == rs2)));

  // Flush kills the ID instruction, so IF is free to fetch the branch target.
  assign stall = !flush && if_valid && (hazard || !ex_ready);

  fwd_mux u_fwd1 (
    .rs(rs1), .rf_data(rf_data1),
    .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .wb_wr(wb_wr), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_data(fwd1)
  );

  fwd_mux u_fwd2 (
    .rs(rs2), .rf_data(rf_data2),
    .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .wb_wr(wb_wr), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_data(fwd2)
  );

  assign opb_sel = rtype ? fwd2
                         : {{(DATA_WIDTH-IMM_WIDTH){imm6[IMM_WIDTH-1]}}, imm6};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_opc   <= '0;
      id_rd    <= '0;
      id_opa   <= '0;
      id_opb   <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (ex_ready) begin
      if (if_valid && !hazard) begin
        id_valid <= 1'b1;
        id_opc   <= opc;
        id_rd    <= rd;
        id_opa   <= fwd1;
        id_opb   <= opb_sel;
        id_pc    <= if_pc;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef OPFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID/operand-fetch stage of the 16-bit pipelined core.
- Decodes the instruction from IF and drives the two read addresses of the 8-entry register file (R7 holds PC).
- Takes the register-file read data, applies EX and WB forwarding, detects load-use hazards, and registers the operands into the ID/EX pipeline register.
- Stall and flush are handled here and in no other stage.

Parameters:
DATA_WIDTH, 16, datapath and instruction width
ADDR_WIDTH, 3, register address width (8 registers)
LOAD_OPC, 4'hA, opcode of the load instruction

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF holds a valid instruction
if_instr  in  16  instruction word
if_pc  in  16  PC of if_instr
stall  out  1  hold IF (PC and if_instr) this cycle
rf_addr1  out  3  register file read address 1 (= instr[8:6])
rf_addr2  out  3  register file read address 2 (= instr[5:3])
rf_data1  in  16  register file read data 1 (combinational)
rf_data2  in  16  register file read data 2 (combinational)
ex_valid  in  1  EX stage holds a valid instruction
ex_wr  in  1  EX instruction writes a register
ex_waddr  in  3  EX destination register
ex_wdata  in  16  EX result
ex_is_load  in  1  EX instruction is a load (data not yet available)
wb_wr  in  1  WB writes the register file this cycle
wb_waddr  in  3  WB destination register
wb_wdata  in  16  WB write data
ex_ready  in  1  EX accepts ID/EX contents this cycle
flush  in  1  taken branch: kill the instruction in ID and in ID/EX
id_valid  out  1  ID/EX register valid
id_opc  out  4  opcode
id_rd  out  3  destination register
id_opa  out  16  operand A
id_opb  out  16  operand B, or sign-extended imm6 for I-type
id_pc  out  16  PC of the instruction

Behaviour:
- Instruction fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- Opcodes 0-7 are R-type and use rs1 and rs2.
- Opcodes 8-15 are I-type and use rs1 only; opb = imm6 sign-extended to 16 bits.
- The instruction in ID is if_instr; the stage holds no separate instruction register.
- rf_addr1 and rf_addr2 are combinational from if_instr.
- Forwarding, per operand, in priority order:
  - EX (ex_valid & ex_wr & !ex_is_load & ex_waddr==rs)
  - then WB (wb_wr & wb_waddr==rs)
  - then rf_data.
- Forwarding applies to all addresses including R7.
- Load-use hazard: if_valid & ex_valid & ex_is_load & ex_wr & ex_waddr matches a used source (rs2 only for R-type). Response:
  - stall=1
  - bubble inserted (id_valid=0 next cycle if ex_ready)
  - exactly one stall cycle per hazard.
- Backpressure: ex_ready=0 -> all ID/EX outputs hold and stall=1. stall = hazard | !ex_ready.
- ID/EX register update:
  - On a clk edge with ex_ready=1, ID/EX loads the instruction if if_valid & !hazard & !flush; otherwise it loads a bubble.
  - On a bubble only id_valid clears; the data outputs keep their old values.
- flush has the highest priority and acts even when ex_ready=0: id_valid<=0 and stall=0.
- Latency: one clock from if_instr accepted to id_* valid.
- Reset (async, rst_n=0):
  - id_valid=0, id_opc=0, id_rd=0, id_opa=0, id_opb=0, id_pc=0.
  - stall is combinational and reads 0 while if_valid=0.
  - Reset mid-stall discards the held instruction.

Optional Feature:
- Macro OPFETCH_STALL_CNT_EN.
- Defined: adds output stall_cnt[15:0], which counts cycles with stall=1. The counter saturates at 16'hFFFF and resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package core_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH
  - opcode constants, including LOAD_OPC
  - instruction field bit positions
  - an is_rtype helper.
- Sub-module fwd_mux: one instance per operand. Inputs are rs, rf_data and the EX/WB tuples; output is the forwarded value.

Test Plan:
1. R0=3, R1=5, no forwarding; instr ADD rd=2,rs1=0,rs2=1 -> next cycle id_valid=1, id_opa=3, id_opb=5, id_rd=2.
2. EX writes R1=0x1234 and WB writes R1=0x00FF in the same cycle; instr reads rs2=1 -> id_opb=0x1234 (EX beats WB).
3. Load to R4 in EX, instr uses rs1=4 -> stall=1 for one cycle and a bubble is inserted. Next cycle WB supplies R4=0x0042 and id_opa=0x0042.
4. I-type with imm6=6'b111110 -> id_opb=16'hFFFE. I-type with rs2 field matching an EX load -> no stall.
5. ex_ready=0 for 3 cycles with a valid instr -> stall=1 and outputs unchanged. flush during the hold -> id_valid=0 next edge.
6. rst_n low mid-stall -> all id_* = 0 immediately. After release, the first instr reaches id_valid=1 one cycle after being presented.
